// File: rtl/fifo_pkg.sv
// Shared defaults and types for the router byte FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one write port and a
// registered read port, all cleared by reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo.sv
// Single-clock byte FIFO: wrap-flag pointers,
// full/empty decode and request gating.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                wr_acc;
  logic                rd_acc;

  // MSB is the wrap flag; index bits address the array
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  =
    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo against a queue model.
module tb_fifo;
  import fifo_pkg::*;

  localparam int D = 16;

  logic  clk;
  logic  rst;
  logic  wr_en;
  logic  rd_en;
  data_t data_in;
  data_t data_out;
  logic  full;
  logic  empty;

  int checks;
  int failures;

  data_t q[$];
  data_t exp_out;

  fifo dut (
    .data_in  (data_in),
    .wr_en    (wr_en),
    .clk      (clk),
    .rst      (rst),
    .data_out (data_out),
    .rd_en    (rd_en),
    .full     (full),
    .empty    (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle and advance the model by the FIFO rules
  task automatic step(input logic w, input logic r,
                      input data_t d);
    bit wa;
    bit ra;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    wa = w && (q.size() < D);
    ra = r && (q.size() > 0);
    @(posedge clk);
    if (ra) exp_out = q.pop_front();
    if (wa) q.push_back(d);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    data_in = '0;
    #3;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_init e=%b f=%b d=%h want 1 0 00",
               empty, full, data_out);
    end
    @(posedge clk);
    #4;
    rst = 1'b1;
    q.delete();
    exp_out = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, data_t'(8'h60 + i));
    step(1'b0, 1'b1, '0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid e=%b f=%b d=%h want 1 0 00",
               empty, full, data_out);
    end
    #1;
    rst = 1'b1;
    q.delete();
    exp_out = '0;
    step(1'b0, 1'b1, '0);
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_read d=%h e=%b want 00 1",
               data_out, empty);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, data_t'(8'h10 + i));
      checks++;
      if (full !== (i == D - 1) || empty !== 1'b0) begin
        failures++;
        $display("FAIL fill_%0d f=%b e=%b", i, full, empty);
      end
    end
    step(1'b1, 1'b0, 8'hAA);
    checks++;
    if (full !== 1'b1 || q.size() != D) begin
      failures++;
      $display("FAIL fill_drop f=%b want 1", full);
    end
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== data_t'(8'h10 + i) ||
          empty !== (i == D - 1) || full !== 1'b0) begin
        failures++;
        $display("FAIL drain_%0d d=%h want %h e=%b",
                 i, data_out, 8'h10 + i, empty);
      end
    end
    step(1'b0, 1'b1, '0);
    checks++;
    if (data_out !== 8'h1F || empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_extra d=%h want 1f", data_out);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, data_t'($urandom));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== exp_out) begin
        failures++;
        $display("FAIL wrap_pre_%0d d=%h want %h",
                 i, data_out, exp_out);
      end
    end
    for (int i = 0; i < D; i++)
      step(1'b1, 1'b0, data_t'(8'h40 + i));
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL wrap_full f=%b e=%b want 1 0", full, empty);
    end
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== data_t'(8'h40 + i)) begin
        failures++;
        $display("FAIL wrap_rd_%0d d=%h want %h",
                 i, data_out, 8'h40 + i);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty e=%b want 1", empty);
    end
  endtask

  task automatic test_simul;
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, data_t'(8'h80 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, data_t'($urandom));
      checks++;
      if (data_out !== exp_out || full !== 1'b0 ||
          empty !== 1'b0 || q.size() != 5) begin
        failures++;
        $display("FAIL simul_%0d d=%h want %h f=%b e=%b",
                 i, data_out, exp_out, full, empty);
      end
    end
    for (int i = 0; i < 11; i++)
      step(1'b1, 1'b0, data_t'($urandom));
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL simul_fill f=%b want 1", full);
    end
    step(1'b1, 1'b1, 8'hEE);
    checks++;
    if (full !== 1'b0 || data_out !== exp_out || q.size() != D - 1) begin
      failures++;
      $display("FAIL simul_full f=%b d=%h want 0 %h",
               full, data_out, exp_out);
    end
    while (q.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 8'h5C);
    checks++;
    if (empty !== 1'b0 || data_out !== exp_out) begin
      failures++;
      $display("FAIL simul_empty e=%b d=%h want 0 %h",
               empty, data_out, exp_out);
    end
    step(1'b0, 1'b1, '0);
    checks++;
    if (data_out !== 8'h5C || empty !== 1'b1) begin
      failures++;
      $display("FAIL simul_empty_rd d=%h want 5c", data_out);
    end
  endtask

  task automatic test_random;
    bit ef;
    bit ee;
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom), 1'($urandom), data_t'($urandom));
      ef = (q.size() == D);
      ee = (q.size() == 0);
      checks++;
      if (data_out !== exp_out || full !== ef || empty !== ee) begin
        failures++;
        $display("FAIL rand_%0d d=%h want %h f=%b/%b e=%b/%b",
                 i, data_out, exp_out, full, ef, empty, ee);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul();
    test_random();
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
